player_walk_ctrl: RTL and testbench



---
 rtl/player_walk_ctrl_if.sv | 22 ++
 rtl/player_walk_ctrl.sv | 140 ++++++++++++++
 tb/tb_player_walk_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/player_walk_ctrl_if.sv
// Collision-map lookup bus between the walk controller (master) and the tile map (slave).
// map_blocked answers the request exactly one cycle after map_req.
interface player_walk_ctrl_if;
    logic       map_req;
    logic [5:0] map_tx;
    logic [4:0] map_ty;
    logic       map_blocked;

    modport master (
        output map_req,
        output map_tx,
        output map_ty,
        input  map_blocked
    );

    modport slave (
        input  map_req,
        input  map_tx,
        input  map_ty,
        output map_blocked
    );
endinterface

// File: rtl/player_walk_ctrl.sv
// Tile-aligned player movement: button sync, collision lookup, and one-pixel-per-tick walking
// on a 16-px grid, driving the sprite selector's direction/step and the renderer's position.
module player_walk_ctrl #(
    parameter int FRAME_DIV  = 416667,
    parameter int X_MAX_TILE = 39,
    parameter int Y_MAX_TILE = 29,
    parameter int START_TX   = 1,
    parameter int START_TY   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                btn,
    player_walk_ctrl_if.master        map,
    output logic [3:0]                dir_out,
    output logic [1:0]                step,
    output logic [9:0]                pos_x,
    output logic [8:0]                pos_y,
    output logic                      moving
);

    localparam int              TW        = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(FRAME_DIV - 1);
    localparam logic [9:0]      RST_X     = 10'(START_TX * 16);
    localparam logic [8:0]      RST_Y     = 9'(START_TY * 16);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FACE, S_WALK} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_btn_meta;
    logic [3:0]      r_btn_sync;
    logic [TW-1:0]   r_tick_cnt;
    logic [3:0]      r_dir;
    logic [3:0]      r_pix_cnt;
    logic [1:0]      r_step;
    logic [9:0]      r_pos_x;
    logic [8:0]      r_pos_y;

    logic            w_tick;
    logic            w_onehot;
    logic            w_in_range;
    logic [5:0]      w_tx;
    logic [4:0]      w_ty;
    logic [5:0]      w_tgt_tx;
    logic [4:0]      w_tgt_ty;
    logic [3:0]      w_pix_next;

    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_onehot   = $onehot(r_btn_sync);
    assign w_tx       = r_pos_x[9:4];
    assign w_ty       = r_pos_y[8:4];
    assign w_pix_next = r_pix_cnt + 4'd1;

    // Target tile and grid-boundary check; edge tiles (incl. row/col 0) fall back to a face-only turn.
    always_comb begin
        w_tgt_tx   = w_tx;
        w_tgt_ty   = w_ty;
        w_in_range = 1'b0;
        case (r_btn_sync)
            4'b1000: begin w_tgt_ty = w_ty - 5'd1; w_in_range = (w_ty != '0); end
            4'b0100: begin w_tgt_ty = w_ty + 5'd1; w_in_range = (w_ty < 5'(Y_MAX_TILE)); end
            4'b0010: begin w_tgt_tx = w_tx - 6'd1; w_in_range = (w_tx != '0); end
            4'b0001: begin w_tgt_tx = w_tx + 6'd1; w_in_range = (w_tx < 6'(X_MAX_TILE)); end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_onehot) w_next = w_in_range ? S_LOOKUP : S_FACE;
            S_LOOKUP: w_next = map.map_blocked ? S_FACE : S_WALK;
            S_FACE:   w_next = S_IDLE;
            S_WALK:   if (w_tick && (r_pix_cnt == 4'd15)) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        map.map_req = 1'b0;
        map.map_tx  = '0;
        map.map_ty  = '0;
        dir_out     = '0;
        moving      = 1'b0;
        case (r_state)
            S_IDLE: if (w_onehot && w_in_range) begin
                map.map_req = 1'b1;
                map.map_tx  = w_tgt_tx;
                map.map_ty  = w_tgt_ty;
            end
            S_FACE: dir_out = r_dir;
            S_WALK: begin dir_out = r_dir; moving = 1'b1; end
            default: ;
        endcase
    end

    // Direction is latched on leaving IDLE so both FACE and WALK see the same one-hot value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_meta <= '0;
            r_btn_sync <= '0;
            r_tick_cnt <= '0;
            r_dir      <= '0;
            r_pix_cnt  <= '0;
            r_step     <= '0;
            r_pos_x    <= RST_X;
            r_pos_y    <= RST_Y;
        end else begin
            r_btn_meta <= btn;
            r_btn_sync <= r_btn_meta;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_onehot) r_dir <= r_btn_sync;
                    r_pix_cnt <= '0;
                    r_step    <= '0;
                end
                S_WALK: if (w_tick) begin
                    if (r_dir[3]) r_pos_y <= r_pos_y - 9'd1;
                    if (r_dir[2]) r_pos_y <= r_pos_y + 9'd1;
                    if (r_dir[1]) r_pos_x <= r_pos_x - 10'd1;
                    if (r_dir[0]) r_pos_x <= r_pos_x + 10'd1;
                    r_pix_cnt <= w_pix_next;
                    r_step    <= w_pix_next[3:2];
                end
                default: ;
            endcase
        end
    end

    assign step  = r_step;
    assign pos_x = r_pos_x;
    assign pos_y = r_pos_y;

endmodule

// File: tb/tb_player_walk_ctrl.sv
// Directed bench for player_walk_ctrl with a 4-cycle frame tick.
module tb_player_walk_ctrl;

    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] dir_out;
    logic [1:0] step;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic       moving;

    player_walk_ctrl_if m_if();

    player_walk_ctrl #(
        .FRAME_DIV  (FD),
        .X_MAX_TILE (39),
        .Y_MAX_TILE (29),
        .START_TX   (1),
        .START_TY   (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .map     (m_if),
        .dir_out (dir_out),
        .step    (step),
        .pos_x   (pos_x),
        .pos_y   (pos_y),
        .moving  (moving)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int step_seq [16] = '{0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic wait_req(output bit seen, output logic [5:0] tx, output logic [4:0] ty);
        seen = 1'b0; tx = '0; ty = '0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (m_if.map_req) begin seen = 1'b1; tx = m_if.map_tx; ty = m_if.map_ty; end
        end
    endtask

    // Follows one walk from its first WALK cycle to its end, checking step per pixel.
    task automatic watch_walk(input string tag, input logic [3:0] dir, input int release_at,
                              input int dx, input int dy);
        int k, g;
        bit dir_bad;
        logic [9:0] px, sx;
        logic [8:0] py, sy;
        g = 0;
        while (!moving && g < 8) begin @(negedge clk); g++; end
        check({tag, "_start"}, moving, 1);
        sx = pos_x; sy = pos_y; px = pos_x; py = pos_y; k = 0; dir_bad = 1'b0;
        for (int i = 0; i < 100 && moving; i++) begin
            @(negedge clk);
            if (i == release_at) btn = '0;
            if (pos_x != px || pos_y != py) begin
                k++;
                if (k <= 16) check($sformatf("%s_step%0d", tag, k), step, step_seq[k-1]);
                px = pos_x; py = pos_y;
            end
            if (moving && dir_out != dir) dir_bad = 1'b1;
        end
        check({tag, "_len"}, k, 16);
        check({tag, "_dir_held"}, dir_bad, 0);
        check({tag, "_end_dir"}, dir_out, 0);
        check({tag, "_end_moving"}, moving, 0);
        check({tag, "_x"}, pos_x, 32'(int'(sx) + dx));
        check({tag, "_y"}, pos_y, 32'(int'(sy) + dy));
    endtask

    task automatic press_walk(input string tag, input logic [3:0] dir, input int etx, input int ety,
                              input logic [3:0] after, input int release_at, input int dx, input int dy);
        bit seen;
        logic [5:0] tx;
        logic [4:0] ty;
        btn = dir;
        wait_req(seen, tx, ty);
        check({tag, "_req"}, seen, 1);
        check({tag, "_tx"}, tx, etx);
        check({tag, "_ty"}, ty, ety);
        btn = after;
        watch_walk(tag, dir, release_at, dx, dy);
    endtask

    task automatic scan(input logic [3:0] b, input bit pulse, input int cycles,
                        output int n_req, output int n_dir, output logic [3:0] last_dir);
        n_req = 0; n_dir = 0; last_dir = '0;
        btn = b;
        if (pulse) begin @(negedge clk); btn = '0; end
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (m_if.map_req) n_req++;
            if (dir_out != '0) begin n_dir++; last_dir = dir_out; end
        end
        btn = '0;
    endtask

    initial begin
        bit seen, done;
        logic [5:0] tx;
        logic [4:0] ty;
        logic [3:0] ld;
        logic [9:0] maxx;
        int nr, nd, g;

        rst = 1'b1; btn = '0; m_if.map_blocked = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_x", pos_x, 16);
        check("rst_y", pos_y, 16);
        check("rst_dir", dir_out, 0);
        check("rst_step", step, 0);
        check("rst_moving", moving, 0);
        check("rst_req", m_if.map_req, 0);

        press_walk("right", 4'b0001, 2, 1, 4'b0000, -1, 16, 0);

        // Blocked up move: exactly one FACE cycle.
        btn = 4'b1000;
        wait_req(seen, tx, ty);
        check("blk_req", seen, 1);
        check("blk_tx", tx, 2);
        check("blk_ty", ty, 0);
        m_if.map_blocked = 1'b1; btn = '0;
        @(negedge clk);
        check("blk_lookup_dir", dir_out, 0);
        @(negedge clk);
        m_if.map_blocked = 1'b0;
        check("blk_face_dir", dir_out, 4'b1000);
        check("blk_face_step", step, 0);
        check("blk_face_moving", moving, 0);
        check("blk_face_x", pos_x, 32);
        check("blk_face_y", pos_y, 16);
        @(negedge clk);
        check("blk_after_dir", dir_out, 0);
        check("blk_after_moving", moving, 0);

        press_walk("left1", 4'b0010, 1, 1, 4'b0000, -1, -16, 0);
        press_walk("left0", 4'b0010, 0, 1, 4'b0000, -1, -16, 0);

        scan(4'b0010, 1'b1, 8, nr, nd, ld);
        check("lbound_req", nr, 0);
        check("lbound_faces", nd, 1);
        check("lbound_dir", ld, 4'b0010);
        check("lbound_x", pos_x, 0);

        // Continuous walking right to the last column.
        btn = 4'b0001; maxx = '0; done = 1'b0;
        for (int i = 0; i < 3200 && !done; i++) begin
            @(negedge clk);
            if (pos_x > maxx) maxx = pos_x;
            if (pos_x == 10'd624 && !moving) done = 1'b1;
        end
        btn = '0;
        repeat (8) begin @(negedge clk); if (pos_x > maxx) maxx = pos_x; end
        check("march_done", done, 1);
        check("march_max_x", maxx, 624);

        scan(4'b0001, 1'b1, 8, nr, nd, ld);
        check("rbound_req", nr, 0);
        check("rbound_faces", nd, 1);
        check("rbound_dir", ld, 4'b0001);
        check("rbound_x", pos_x, 624);

        scan(4'b1010, 1'b0, 8, nr, nd, ld);
        check("multi_req", nr, 0);
        check("multi_dir", nd, 0);
        scan(4'b0000, 1'b0, 6, nr, nd, ld);
        check("none_req", nr, 0);
        check("none_dir", nd, 0);

        // Two back-to-back walks down with the button held.
        btn = 4'b0100;
        g = 0;
        while (!moving && g < 10) begin @(negedge clk); g++; end
        check("b2b_start", moving, 1);
        g = 0;
        while (moving && g < 100) begin @(negedge clk); g++; end
        check("b2b_y1", pos_y, 32);
        check("b2b_req_first_idle", m_if.map_req, 1);
        check("b2b_ty", m_if.map_ty, 3);
        g = 0;
        while (!moving && g < 10) begin @(negedge clk); g++; end
        check("b2b_gap", g, 2);
        btn = '0;
        g = 0;
        while (moving && g < 100) begin @(negedge clk); g++; end
        check("b2b_y2", pos_y, 48);

        press_walk("chg", 4'b0010, 38, 3, 4'b0100, 20, -16, 0);

        // Reset asserted in the middle of a walk.
        btn = 4'b0100;
        wait_req(seen, tx, ty);
        check("rw_req", seen, 1);
        btn = '0;
        repeat (20) @(negedge clk);
        check("rw_moving", moving, 1);
        rst = 1'b1;
        #1;
        check("rw_async_x", pos_x, 16);
        check("rw_async_moving", moving, 0);
        @(negedge clk);
        check("rw_x", pos_x, 16);
        check("rw_y", pos_y, 16);
        check("rw_dir", dir_out, 0);
        check("rw_step", step, 0);
        check("rw_moving2", moving, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rw_stay_y", pos_y, 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
